// File: rtl/mem_resp_pkg.sv
// Shared types and widths for the mem_responder slave: FSM states,
// data/byte-enable widths and the wait-state counter width.
package mem_resp_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = WORD_W / 8;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Overlay the enabled byte lanes of new_word onto old_word.
    function automatic logic [WORD_W-1:0] merge_bytes(
        input logic [WORD_W-1:0] old_word,
        input logic [WORD_W-1:0] new_word,
        input logic [BE_W-1:0]   lane_en
    );
        logic [WORD_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < BE_W; i++) begin
            if (lane_en[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/mem_word_array.sv
// Word-organised storage: synchronous byte-enable write, combinational read.
// Contents are deliberately not reset.
module mem_word_array
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic                              clk,
    input  logic                              wr_en,
    input  logic [AW-1:0]                     wr_idx,
    input  logic [mem_resp_pkg::WORD_W-1:0]   wr_data,
    input  logic [mem_resp_pkg::BE_W-1:0]     wr_be,
    input  logic [AW-1:0]                     rd_idx,
    output logic [mem_resp_pkg::WORD_W-1:0]   rd_data
);
    import mem_resp_pkg::*;

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= merge_bytes(mem[wr_idx], wr_data, wr_be);
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/mem_responder.sv
// Single-port memory slave with a fixed number of wait states per transfer,
// address error checking and a one-cycle registered ready/err/rdata response.
module mem_responder
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        ready,
    output logic        err,
    output logic [31:0] rdata,
    output logic        busy
);
    import mem_resp_pkg::*;

    localparam int                AW         = $clog2(DEPTH_WORDS);
    localparam logic [WORD_W-1:0] ADDR_LIMIT = WORD_W'(4 * DEPTH_WORDS);
    localparam logic [CNT_W-1:0]  WAIT_LOAD  = CNT_W'(WAIT_CYCLES);

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic               cap_we;
    logic [WORD_W-1:0]  cap_addr;
    logic [WORD_W-1:0]  cap_wdata;
    logic [BE_W-1:0]    cap_be;

    logic               sel_we;
    logic [WORD_W-1:0]  sel_addr;
    logic               sel_bad;
    logic [AW-1:0]      sel_idx;
    logic [WORD_W-1:0]  rd_word;
    logic               enter_resp;
    logic               wr_en;

    // With zero wait states the response is built straight from the live
    // request inputs, so the lookup follows the inputs while IDLE.
    always_comb begin
        sel_we   = (state == IDLE) ? we   : cap_we;
        sel_addr = (state == IDLE) ? addr : cap_addr;
        sel_bad  = (sel_addr[1:0] != 2'b00) || (sel_addr >= ADDR_LIMIT);
        sel_idx  = sel_addr[AW+1:2];
    end

    assign enter_resp = ((state == IDLE) && req && (WAIT_CYCLES == 0)) ||
                        ((state == WAIT) && (wait_cnt <= CNT_W'(1)));

    // err is registered on entry to RESP, so it already flags a rejected
    // transfer by the time the write would land.
    assign wr_en = (state == RESP) && cap_we && !err && !reset;

    assign busy = (state != IDLE) || (req && !reset);

    mem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_idx  (cap_addr[AW+1:2]),
        .wr_data (cap_wdata),
        .wr_be   (cap_be),
        .rd_idx  (sel_idx),
        .rd_data (rd_word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            ready     <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
            cap_we    <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            cap_be    <= '0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
            if (enter_resp) begin
                ready <= 1'b1;
                err   <= sel_bad;
                rdata <= (sel_bad || sel_we) ? '0 : rd_word;
            end

            case (state)
                IDLE: begin
                    if (req) begin
                        cap_we    <= we;
                        cap_addr  <= addr;
                        cap_wdata <= wdata;
                        cap_be    <= be;
                        wait_cnt  <= WAIT_LOAD;
                        state     <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - CNT_W'(1);
                    if (wait_cnt <= CNT_W'(1)) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
